// File: rtl/mem_interface_unit.sv
// Memory interface unit: turns multicycle-controller memory strobes into single
// req/ack bus transactions, owns IR and MDR, and stalls the controller meanwhile.
`timescale 1ns/1ps
module mem_interface_unit #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iord,
    input  logic [AW-1:0] adr_pc,
    input  logic [AW-1:0] adr_alu,
    input  logic          irwrite,
    input  logic          memwrite,
    input  logic          mdr_load,
    input  logic [DW-1:0] wd,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    input  logic          bus_err,
    output logic [DW-1:0] instr,
    output logic [5:0]    op,
    output logic [5:0]    funct,
    output logic [DW-1:0] mdr,
    output logic          stall,
    output logic          fault
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_STORE, K_LOAD} kind_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    kind_t         r_kind;
    kind_t         w_kind;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_mdr;
    logic [7:0]    r_cnt;
    logic          r_req;
    logic          r_we;
    logic          r_fault;

    logic          w_req_any;
    logic          w_one_strobe;
    logic [AW-1:0] w_addr;
    logic          w_accept;
    logic          w_reject;
    logic          w_bus_ok;
    logic          w_bus_fail;

    assign w_req_any    = irwrite | memwrite | mdr_load;
    assign w_one_strobe = ({irwrite, memwrite, mdr_load} == 3'b100) ||
                          ({irwrite, memwrite, mdr_load} == 3'b010) ||
                          ({irwrite, memwrite, mdr_load} == 3'b001);
    assign w_addr       = iord ? adr_alu : adr_pc;
    assign w_kind       = irwrite ? K_FETCH : (memwrite ? K_STORE : K_LOAD);

    assign w_accept   = (r_state == S_IDLE) && w_req_any && w_one_strobe && (w_addr[1:0] == 2'b00);
    assign w_reject   = (r_state == S_IDLE) && w_req_any && !(w_one_strobe && (w_addr[1:0] == 2'b00));
    // An err beat wins over a simultaneous ack.
    assign w_bus_ok   = (r_state == S_BUSY) && bus_ack && !bus_err;
    assign w_bus_fail = (r_state == S_BUSY) && (bus_err || (!bus_ack && (r_cnt == CNT_LAST)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                end else if (w_reject) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_BUSY: begin
                if (w_bus_ok || w_bus_fail) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stall is gated by reset so an abandoned access releases the controller at once.
    always_comb begin
        stall = reset && w_req_any && (r_state != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind  <= K_FETCH;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ir    <= '0;
            r_mdr   <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_kind  <= w_kind;
                        r_addr  <= w_addr;
                        r_wdata <= wd;
                        r_req   <= 1'b1;
                        r_we    <= memwrite;
                        r_cnt   <= '0;
                    end else if (w_reject) begin
                        r_fault <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_bus_fail) begin
                        r_fault <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                    end else if (w_bus_ok) begin
                        if (r_kind == K_FETCH) begin
                            r_ir <= bus_rdata;
                        end else if (r_kind == K_LOAD) begin
                            r_mdr <= bus_rdata;
                        end
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign instr     = r_ir;
    assign op        = r_ir[31:26];
    assign funct     = r_ir[5:0];
    assign mdr       = r_mdr;
    assign fault     = r_fault;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Scoreboard bench for mem_interface_unit: directed accesses push expected bus
// and completion records; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_interface_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iord = 1'b0;
    logic [AW-1:0] adr_pc = '0;
    logic [AW-1:0] adr_alu = '0;
    logic          irwrite = 1'b0;
    logic          memwrite = 1'b0;
    logic          mdr_load = 1'b0;
    logic [DW-1:0] wd = '0;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          bus_err;
    logic [DW-1:0] instr;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [DW-1:0] mdr;
    logic          stall;
    logic          fault;

    mem_interface_unit #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(rst_n), .iord(iord), .adr_pc(adr_pc), .adr_alu(adr_alu),
        .irwrite(irwrite), .memwrite(memwrite), .mdr_load(mdr_load), .wd(wd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .instr(instr), .op(op), .funct(funct), .mdr(mdr), .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } bus_exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mdr;
        logic        fault;
        int unsigned stall_cyc;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Bus slave: acks (or errors) in the rsp_delay-th cycle of bus_req; 0 = never.
    int unsigned rsp_delay = 0;
    logic        rsp_ack = 1'b0;
    logic        rsp_err = 1'b0;
    logic        rsp_force = 1'b0;
    logic [31:0] rsp_data = '0;
    int unsigned busy_cnt = 0;

    initial begin
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = rsp_force;
            bus_err = 1'b0;
            if (rsp_force) bus_rdata = rsp_data;
            if (bus_req) begin
                busy_cnt++;
                if (busy_cnt == rsp_delay) begin
                    bus_ack   = rsp_ack;
                    bus_err   = rsp_err;
                    bus_rdata = rsp_data;
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Monitor
    bus_exp_t    cur_bus;
    done_exp_t   cur_done;
    logic        prev_req = 1'b0;
    logic        bus_unexp = 1'b0;
    int unsigned stall_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                stall_cnt = 0;
            end else begin
                if (bus_req) begin
                    if (!prev_req) begin
                        if (bus_q.size() == 0) begin
                            bus_unexp = 1'b1;
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_bus_req: got bus_req=1 addr=0x%08h expected no transaction", bus_addr);
                        end else begin
                            bus_unexp = 1'b0;
                            cur_bus = bus_q.pop_front();
                        end
                    end
                    if (!bus_unexp) begin
                        check("bus_addr", bus_addr, cur_bus.addr);
                        check("bus_we", 32'(bus_we), 32'(cur_bus.we));
                        check("bus_wdata", bus_wdata, cur_bus.wdata);
                    end
                end
                prev_req = bus_req;
                if (irwrite || memwrite || mdr_load) begin
                    if (stall) begin
                        stall_cnt++;
                    end else begin
                        if (done_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_done: got completion expected none queued");
                        end else begin
                            cur_done = done_q.pop_front();
                            check("instr", instr, cur_done.instr);
                            check("op", 32'(op), 32'(cur_done.instr[31:26]));
                            check("funct", 32'(funct), 32'(cur_done.instr[5:0]));
                            check("mdr", mdr, cur_done.mdr);
                            check("fault", 32'(fault), 32'(cur_done.fault));
                            check("stall_cycles", stall_cnt, cur_done.stall_cyc);
                            check("bus_req_done", 32'(bus_req), 32'd0);
                        end
                        stall_cnt = 0;
                    end
                end else begin
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic access(input logic irw, input logic mw, input logic ml, input logic sel,
                          input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wdv,
                          input int unsigned dly, input logic ack, input logic err,
                          input logic [31:0] rdata, input logic exp_bus, input logic [31:0] exp_addr,
                          input logic [31:0] exp_instr, input logic [31:0] exp_mdr,
                          input logic exp_fault, input int unsigned exp_stall);
        bus_exp_t  b;
        done_exp_t d;
        logic      seen;
        if (exp_bus) begin
            b.addr  = exp_addr;
            b.we    = mw;
            b.wdata = wdv;
            bus_q.push_back(b);
        end
        d.instr     = exp_instr;
        d.mdr       = exp_mdr;
        d.fault     = exp_fault;
        d.stall_cyc = exp_stall;
        done_q.push_back(d);
        rsp_delay = dly;
        rsp_ack   = ack;
        rsp_err   = err;
        rsp_data  = rdata;
        iord      = sel;
        adr_pc    = pc;
        adr_alu   = alu;
        wd        = wdv;
        irwrite   = irw;
        memwrite  = mw;
        mdr_load  = ml;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!stall) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout: got stall stuck high expected drop within 100 cycles");
        end
        @(posedge clk);
        #1;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        mdr_load = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus_exp_t b;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_mdr", mdr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // irw mw ml sel pc alu wd dly ack err rdata | bus addr instr mdr fault stall
        access(1,0,0,0, 32'h40,  32'h0,   32'h0,        3,1,0, 32'h012A4020, 1,32'h40,  32'h012A4020,32'h0, 0,4);
        access(0,1,0,1, 32'h0,   32'h100, 32'hDEADBEEF, 1,1,0, 32'h12345678, 1,32'h100, 32'h012A4020,32'h0, 0,2);
        access(0,0,1,1, 32'h0,   32'h102, 32'h0,        0,0,0, 32'h0,        0,32'h0,   32'h012A4020,32'h0, 1,1);
        access(0,0,1,1, 32'h0,   32'h104, 32'h0,        1,1,0, 32'h55,       1,32'h104, 32'h012A4020,32'h55,1,2);
        access(1,0,0,0, 32'h44,  32'h3,   32'h0,        2,1,0, 32'h8C820004, 1,32'h44,  32'h8C820004,32'h55,1,3);

        // Reset in the middle of a fetch; the late ack must not be captured.
        b.addr = 32'h500; b.we = 1'b0; b.wdata = 32'h0;
        bus_q.push_back(b);
        rsp_delay = 0; iord = 1'b0; adr_pc = 32'h500; wd = 32'h0; irwrite = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_fault", 32'(fault), 32'd0);
        check("midrst_instr", instr, 32'd0);
        irwrite = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_force = 1'b1;
        rsp_data  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rsp_force = 1'b0;
        @(negedge clk);
        check("stale_ack_instr", instr, 32'd0);
        check("stale_ack_mdr", mdr, 32'd0);
        check("stale_ack_req", 32'(bus_req), 32'd0);
        @(posedge clk);
        #1;

        access(1,0,0,0, 32'h200, 32'h0,   32'h0,        0,0,0, 32'h11111111, 1,32'h200, 32'h0,32'h0, 1,16);
        pulse_reset();
        access(1,0,0,0, 32'h300, 32'h0,   32'h0,        2,0,1, 32'hFFFFFFFF, 1,32'h300, 32'h0,32'h0, 1,3);
        pulse_reset();
        access(0,0,1,1, 32'h0,   32'h400, 32'h0,        1,1,1, 32'h0000AAAA, 1,32'h400, 32'h0,32'h0, 1,2);
        pulse_reset();
        access(1,1,0,0, 32'h10,  32'h0,   32'h0,        1,1,0, 32'h0,        0,32'h0,   32'h0,32'h0, 1,1);
        access(0,1,0,1, 32'h0,   32'h8,   32'h0BADF00D, 1,1,0, 32'h0,        1,32'h8,   32'h0,32'h0, 1,2);

        repeat (2) @(posedge clk);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion by 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
